// File: rtl/demux_1_n_stream.sv
// Registered 1:N stream demultiplexer. A single-entry holding register routes
// each input beat to one of NUM_CHANNELS valid/ready outputs.
module demux_1_n_stream #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_CHANNELS = 4,
  localparam int SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
  input  logic                               Clock_In,
  input  logic                               Reset_N_In,
  input  logic                               Enable_In,
  input  logic                               Mode_In,
  input  logic [DATA_WIDTH-1:0]              Data_In,
  input  logic                               Data_Valid_In,
  output logic                               Data_Ready_Out,
  input  logic [SEL_WIDTH-1:0]               Select_In,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] DEMUX_Data_Out,
  output logic [NUM_CHANNELS-1:0]            DEMUX_Valid_Out,
  input  logic [NUM_CHANNELS-1:0]            DEMUX_Ready_In,
  output logic [SEL_WIDTH-1:0]               RR_Pointer_Out,
  output logic                               Busy_Out,
  output logic                               Drop_Error_Out
);

  localparam int PAD_CHANNELS = 1 << SEL_WIDTH;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic [SEL_WIDTH-1:0] LAST_CHANNEL = SEL_WIDTH'(NUM_CHANNELS - 1);

  logic [0:0]            state_q;
  logic [SEL_WIDTH-1:0]  hold_ch_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic [SEL_WIDTH-1:0]  rr_ptr_q;
  logic                  drop_q;

  logic [PAD_CHANNELS-1:0] ready_pad;
  logic [SEL_WIDTH-1:0]    target_ch;
  logic                    full;
  logic                    held_ready;
  logic                    target_ok;
  logic                    accept;
  logic                    drain;
  logic                    load;

  // Ready is widened to a power of two so the held index can never select past the vector.
  assign ready_pad  = PAD_CHANNELS'(DEMUX_Ready_In);
  assign full       = (state_q == ST_FULL);
  assign held_ready = ready_pad[hold_ch_q];

  assign Data_Ready_Out = Reset_N_In & Enable_In & (~full | held_ready);
  assign accept         = Data_Valid_In & Data_Ready_Out;
  assign drain          = full & held_ready;
  assign target_ch      = Mode_In ? rr_ptr_q : Select_In;
  assign load           = accept & target_ok;

  generate
    if (PAD_CHANNELS == NUM_CHANNELS) begin : g_pow2
      assign target_ok = 1'b1;
    end else begin : g_npow2
      assign target_ok = ({1'b0, target_ch} < (SEL_WIDTH + 1)'(NUM_CHANNELS));
    end
  endgenerate

  // A new load wins over a drain, which gives one beat per cycle even across channel changes.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q     <= ST_EMPTY;
      hold_ch_q   <= '0;
      hold_data_q <= '0;
    end else if (load) begin
      state_q     <= ST_FULL;
      hold_ch_q   <= target_ch;
      hold_data_q <= Data_In;
    end else if (drain) begin
      state_q     <= ST_EMPTY;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      rr_ptr_q <= '0;
    end else if (accept && Mode_In) begin
      rr_ptr_q <= (rr_ptr_q == LAST_CHANNEL) ? '0 : rr_ptr_q + SEL_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= accept & ~target_ok;
    end
  end

  // Outputs decode straight from registers, so an asynchronous reset clears them at once.
  always_comb begin
    DEMUX_Data_Out  = '0;
    DEMUX_Valid_Out = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (full && (hold_ch_q == SEL_WIDTH'(k))) begin
        DEMUX_Valid_Out[k]                          = 1'b1;
        DEMUX_Data_Out[k*DATA_WIDTH +: DATA_WIDTH] = hold_data_q;
      end
    end
  end

  assign RR_Pointer_Out = rr_ptr_q;
  assign Busy_Out       = full;
  assign Drop_Error_Out = drop_q;

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Scoreboard bench for demux_1_n_stream: a 4-channel instance for routing and
// handshake scenarios, plus a 3-channel instance for out-of-range selects.
module tb_demux_1_n_stream;

  localparam int DW = 8;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        enable, mode, valid_in, ready_out, busy, drop;
  logic [7:0]  data_in;
  logic [1:0]  select, rr_ptr;
  logic [31:0] dmx_data;
  logic [3:0]  dmx_valid, dmx_ready;

  logic        u3_enable, u3_mode, u3_valid, u3_ready_out, u3_busy, u3_drop;
  logic [7:0]  u3_data;
  logic [1:0]  u3_sel, u3_rr;
  logic [23:0] u3_ddata;
  logic [2:0]  u3_dvalid, u3_dready;

  always #5 clk = ~clk;

  demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CHANNELS(4)) dut (
    .Clock_In(clk), .Reset_N_In(rst_n), .Enable_In(enable), .Mode_In(mode),
    .Data_In(data_in), .Data_Valid_In(valid_in), .Data_Ready_Out(ready_out),
    .Select_In(select), .DEMUX_Data_Out(dmx_data), .DEMUX_Valid_Out(dmx_valid),
    .DEMUX_Ready_In(dmx_ready), .RR_Pointer_Out(rr_ptr), .Busy_Out(busy),
    .Drop_Error_Out(drop)
  );

  demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CHANNELS(3)) dut3 (
    .Clock_In(clk), .Reset_N_In(rst_n), .Enable_In(u3_enable), .Mode_In(u3_mode),
    .Data_In(u3_data), .Data_Valid_In(u3_valid), .Data_Ready_Out(u3_ready_out),
    .Select_In(u3_sel), .DEMUX_Data_Out(u3_ddata), .DEMUX_Valid_Out(u3_dvalid),
    .DEMUX_Ready_In(u3_dready), .RR_Pointer_Out(u3_rr), .Busy_Out(u3_busy),
    .Drop_Error_Out(u3_drop)
  );

  function automatic logic [3:0] exp_valid(int ch);
    return 4'(1 << ch);
  endfunction

  function automatic logic [31:0] exp_data(int ch, logic [7:0] d);
    return 32'(d) << (ch * DW);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b1; mode = 1'b0; valid_in = 1'b0; data_in = '0; select = '0; dmx_ready = 4'hF;
    u3_enable = 1'b1; u3_mode = 1'b0; u3_valid = 1'b0; u3_data = '0; u3_sel = '0; u3_dready = 3'h7;
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({ready_out, dmx_valid, dmx_data, busy, drop, rr_ptr} !== 40'h0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got rdy=%b v=%b d=%h busy=%b drop=%b rr=%0d, expected all 0",
               ready_out, dmx_valid, dmx_data, busy, drop, rr_ptr);
    end
    n_vec++;
    if (u3_ready_out !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_ready3: got %b, expected 0", u3_ready_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (ready_out !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_release: got rdy=%b busy=%b, expected rdy=1 busy=0", ready_out, busy);
    end
  endtask

  task automatic test_addressed();
    beat_t e;
    mode = 1'b0; enable = 1'b1; dmx_ready = 4'hF;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL addr_out[%0d]: got valid=%b, expected a queued beat", i, dmx_valid);
        end else begin
          e = exp_q.pop_front();
          if (dmx_valid !== exp_valid(e.ch) || dmx_data !== exp_data(e.ch, e.data)) begin
            n_err++;
            $display("[TB] FAIL addr_out[%0d]: got v=%b d=%h, expected v=%b d=%h", i,
                     dmx_valid, dmx_data, exp_valid(e.ch), exp_data(e.ch, e.data));
          end
        end
      end
      if (i < 4) begin
        valid_in = 1'b1; data_in = 8'hA0 + 8'(i); select = 2'(i);
        #1;
        n_vec++;
        if (ready_out !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL addr_ready[%0d]: got %b, expected 1", i, ready_out);
        end
        exp_q.push_back('{ch: i, data: 8'hA0 + 8'(i)});
      end else begin
        valid_in = 1'b0;
      end
      tick();
    end
    n_vec++;
    if (dmx_valid !== 4'h0 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL addr_idle: got v=%b busy=%b, expected v=0000 busy=0", dmx_valid, busy);
    end
  endtask

  task automatic test_back_pressure();
    beat_t e;
    mode = 1'b0; enable = 1'b1; dmx_ready = 4'b1011;
    valid_in = 1'b1; data_in = 8'h5C; select = 2'd2;
    exp_q.push_back('{ch: 2, data: 8'h5C});
    tick();
    data_in = 8'h71; select = 2'd1;
    for (int j = 0; j < 5; j++) begin
      #1;
      n_vec++;
      if (dmx_valid !== 4'b0100 || dmx_data !== 32'h005C_0000 || ready_out !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b busy=%b, expected v=0100 d=005c0000 rdy=0 busy=1",
                 j, dmx_valid, dmx_data, ready_out, busy);
      end
      tick();
    end
    dmx_ready = 4'hF;
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("[TB] FAIL bp_drain: got valid=%b, expected a queued beat", dmx_valid);
    end else begin
      e = exp_q.pop_front();
      if (dmx_valid !== exp_valid(e.ch) || dmx_data !== exp_data(e.ch, e.data)) begin
        n_err++;
        $display("[TB] FAIL bp_drain: got v=%b d=%h, expected v=%b d=%h",
                 dmx_valid, dmx_data, exp_valid(e.ch), exp_data(e.ch, e.data));
      end
    end
    n_vec++;
    if (ready_out !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL bp_ready_release: got %b, expected 1", ready_out);
    end
    exp_q.push_back('{ch: 1, data: 8'h71});
    tick();
    valid_in = 1'b0;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("[TB] FAIL bp_next: got valid=%b, expected a queued beat", dmx_valid);
    end else begin
      e = exp_q.pop_front();
      if (dmx_valid !== exp_valid(e.ch) || dmx_data !== exp_data(e.ch, e.data)) begin
        n_err++;
        $display("[TB] FAIL bp_next: got v=%b d=%h, expected v=%b d=%h",
                 dmx_valid, dmx_data, exp_valid(e.ch), exp_data(e.ch, e.data));
      end
    end
    tick();
  endtask

  task automatic test_round_robin();
    beat_t e;
    int    exp_rr = 0;
    mode = 1'b1; enable = 1'b1; dmx_ready = 4'hF;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL rr_out[%0d]: got valid=%b, expected a queued beat", i, dmx_valid);
        end else begin
          e = exp_q.pop_front();
          if (dmx_valid !== exp_valid(e.ch) || dmx_data !== exp_data(e.ch, e.data)) begin
            n_err++;
            $display("[TB] FAIL rr_out[%0d]: got v=%b d=%h, expected v=%b d=%h", i,
                     dmx_valid, dmx_data, exp_valid(e.ch), exp_data(e.ch, e.data));
          end
        end
      end
      if (i < 6) begin
        n_vec++;
        if (rr_ptr !== 2'(exp_rr)) begin
          n_err++;
          $display("[TB] FAIL rr_ptr[%0d]: got %0d, expected %0d", i, rr_ptr, exp_rr);
        end
        valid_in = 1'b1; data_in = 8'hB0 + 8'(i); select = 2'(i + 2);
        exp_q.push_back('{ch: exp_rr, data: 8'hB0 + 8'(i)});
        exp_rr = (exp_rr + 1) % 4;
      end else begin
        valid_in = 1'b0;
      end
      tick();
    end
    mode = 1'b0; valid_in = 1'b1; data_in = 8'hC3; select = 2'd3;
    exp_q.push_back('{ch: 3, data: 8'hC3});
    tick();
    valid_in = 1'b0;
    n_vec++;
    if (rr_ptr !== 2'(exp_rr)) begin
      n_err++;
      $display("[TB] FAIL rr_hold_mode0: got %0d, expected %0d", rr_ptr, exp_rr);
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("[TB] FAIL rr_mode0_out: got valid=%b, expected a queued beat", dmx_valid);
    end else begin
      e = exp_q.pop_front();
      if (dmx_valid !== exp_valid(e.ch) || dmx_data !== exp_data(e.ch, e.data)) begin
        n_err++;
        $display("[TB] FAIL rr_mode0_out: got v=%b d=%h, expected v=%b d=%h",
                 dmx_valid, dmx_data, exp_valid(e.ch), exp_data(e.ch, e.data));
      end
    end
    tick();
  endtask

  task automatic test_out_of_range();
    u3_mode = 1'b0; u3_enable = 1'b1; u3_dready = 3'h7;
    u3_valid = 1'b1; u3_data = 8'hEE; u3_sel = 2'd3;
    #1;
    n_vec++;
    if (u3_ready_out !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL oor_ready: got %b, expected 1", u3_ready_out);
    end
    tick();
    u3_valid = 1'b0;
    n_vec++;
    if (u3_drop !== 1'b1 || u3_dvalid !== 3'b000 || u3_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL oor_drop: got drop=%b v=%b busy=%b, expected drop=1 v=000 busy=0",
               u3_drop, u3_dvalid, u3_busy);
    end
    tick();
    n_vec++;
    if (u3_drop !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL oor_pulse_width: got drop=%b, expected 0", u3_drop);
    end
    u3_valid = 1'b1; u3_data = 8'h33; u3_sel = 2'd2;
    tick();
    n_vec++;
    if (u3_dvalid !== 3'b100 || u3_ddata !== 24'h33_0000) begin
      n_err++;
      $display("[TB] FAIL oor_ch2: got v=%b d=%h, expected v=100 d=330000", u3_dvalid, u3_ddata);
    end
    u3_data = 8'h44; u3_sel = 2'd3;
    tick();
    u3_valid = 1'b0;
    n_vec++;
    if (u3_dvalid !== 3'b000 || u3_busy !== 1'b0 || u3_drop !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL oor_drain_drop: got v=%b busy=%b drop=%b, expected v=000 busy=0 drop=1",
               u3_dvalid, u3_busy, u3_drop);
    end
    tick();
    n_vec++;
    if (u3_drop !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL oor_drain_pulse: got drop=%b, expected 0", u3_drop);
    end
  endtask

  task automatic test_enable_low();
    beat_t e;
    mode = 1'b0; enable = 1'b1; dmx_ready = 4'b1110;
    valid_in = 1'b1; data_in = 8'hE5; select = 2'd0;
    exp_q.push_back('{ch: 0, data: 8'hE5});
    tick();
    enable = 1'b0; mode = 1'b1; data_in = 8'h66; select = 2'd3;
    #1;
    n_vec++;
    if (ready_out !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL en_hold: got rdy=%b busy=%b, expected rdy=0 busy=1", ready_out, busy);
    end
    dmx_ready = 4'hF;
    #1;
    n_vec++;
    if (ready_out !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL en_ready_gated: got %b, expected 0", ready_out);
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("[TB] FAIL en_drain: got valid=%b, expected a queued beat", dmx_valid);
    end else begin
      e = exp_q.pop_front();
      if (dmx_valid !== exp_valid(e.ch) || dmx_data !== exp_data(e.ch, e.data)) begin
        n_err++;
        $display("[TB] FAIL en_drain: got v=%b d=%h, expected v=%b d=%h",
                 dmx_valid, dmx_data, exp_valid(e.ch), exp_data(e.ch, e.data));
      end
    end
    for (int j = 0; j < 2; j++) begin
      tick();
      n_vec++;
      if (busy !== 1'b0 || dmx_valid !== 4'h0 || ready_out !== 1'b0 || rr_ptr !== 2'd2) begin
        n_err++;
        $display("[TB] FAIL en_no_accept[%0d]: got busy=%b v=%b rdy=%b rr=%0d, expected busy=0 v=0000 rdy=0 rr=2",
                 j, busy, dmx_valid, ready_out, rr_ptr);
      end
    end
    mode = 1'b0; enable = 1'b1;
    #1;
    n_vec++;
    if (ready_out !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL en_resume_ready: got %b, expected 1", ready_out);
    end
    exp_q.push_back('{ch: 3, data: 8'h66});
    tick();
    valid_in = 1'b0;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("[TB] FAIL en_resume_out: got valid=%b, expected a queued beat", dmx_valid);
    end else begin
      e = exp_q.pop_front();
      if (dmx_valid !== exp_valid(e.ch) || dmx_data !== exp_data(e.ch, e.data)) begin
        n_err++;
        $display("[TB] FAIL en_resume_out: got v=%b d=%h, expected v=%b d=%h",
                 dmx_valid, dmx_data, exp_valid(e.ch), exp_data(e.ch, e.data));
      end
    end
    tick();
  endtask

  task automatic test_async_reset();
    beat_t e;
    mode = 1'b0; enable = 1'b1; dmx_ready = 4'b1101;
    valid_in = 1'b1; data_in = 8'h9A; select = 2'd1;
    tick();
    valid_in = 1'b0;
    n_vec++;
    if (dmx_valid !== 4'b0010 || busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL ar_held: got v=%b busy=%b, expected v=0010 busy=1", dmx_valid, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ready_out, dmx_valid, dmx_data, busy, drop, rr_ptr} !== 40'h0) begin
      n_err++;
      $display("[TB] FAIL ar_clear: got rdy=%b v=%b d=%h busy=%b drop=%b rr=%0d, expected all 0",
               ready_out, dmx_valid, dmx_data, busy, drop, rr_ptr);
    end
    @(negedge clk);
    rst_n = 1'b1; dmx_ready = 4'hF;
    #1;
    n_vec++;
    if (ready_out !== 1'b1 || busy !== 1'b0 || rr_ptr !== 2'd0 || dmx_valid !== 4'h0) begin
      n_err++;
      $display("[TB] FAIL ar_release: got rdy=%b busy=%b rr=%0d v=%b, expected rdy=1 busy=0 rr=0 v=0000",
               ready_out, busy, rr_ptr, dmx_valid);
    end
    mode = 1'b1; valid_in = 1'b1; data_in = 8'h5A;
    exp_q.push_back('{ch: 0, data: 8'h5A});
    tick();
    valid_in = 1'b0;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("[TB] FAIL ar_resume_out: got valid=%b, expected a queued beat", dmx_valid);
    end else begin
      e = exp_q.pop_front();
      if (dmx_valid !== exp_valid(e.ch) || dmx_data !== exp_data(e.ch, e.data) || rr_ptr !== 2'd1) begin
        n_err++;
        $display("[TB] FAIL ar_resume_out: got v=%b d=%h rr=%0d, expected v=%b d=%h rr=1",
                 dmx_valid, dmx_data, rr_ptr, exp_valid(e.ch), exp_data(e.ch, e.data));
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_addressed();
    test_back_pressure();
    test_round_robin();
    test_out_of_range();
    test_enable_low();
    test_async_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_leftover: got %0d beats outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
